// File: rtl/doppler_sweep_ctrl_if.sv
// doppler_sweep_ctrl_if
//   Frequency-shift interface between the Doppler sweep controller and the
//   shifter it steers.
//   code    : shifter phase-increment magnitude (|k| * bin_step)
//   code_up : shift sign, 1 for positive bins
//   valid   : sample-valid strobe coming back from the shifter
//   slave modport  : controller side (drives code/code_up, observes valid)
//   master modport : shifter side (observes code/code_up, drives valid)
interface doppler_sweep_ctrl_if #(
  parameter int CODE_WIDTH = 32
);
  logic [CODE_WIDTH-1:0] code;
  logic                  code_up;
  logic                  valid;

  modport slave  (output code, output code_up, input  valid);
  modport master (input  code, input  code_up, output valid);
endinterface

// File: rtl/doppler_sweep_ctrl.sv
// doppler_sweep_ctrl
//   Steps a frequency shifter through Doppler bins k = -N..+N. Each bin is
//   held for a programmed number of valid samples (after a short settle
//   window in which valid is ignored), and its end is flagged with bin_end.
//
//   Ports:
//     clk, syn_reset  : clock, synchronous active-high reset
//     start_i         : begin a sweep when idle (latches the inputs below)
//     abort_i         : stop the sweep, return to idle without done
//     bin_step_i      : code increment between adjacent bins
//     n_bins_i        : bins per side (2*n_bins+1 bins in total)
//     dwell_i         : valid samples per bin (0 behaves as 1)
//     fs              : freq-shift interface (code, code_up out; valid in)
//     bin_idx_o       : signed current bin index
//     bin_active_o    : bin is in its counting window
//     bin_end_o       : one-cycle pulse after the last sample of a bin
//     busy_o          : sweep in progress
//     done_o          : one-cycle pulse when the sweep completes
//
//   Optional feature macro DOPPLER_SWEEP_OVF_EN adds ovf_o, a sticky flag
//   set when building the first bin's code carries out of CODE_WIDTH bits.
module doppler_sweep_ctrl #(
  parameter int CODE_WIDTH = 32,
  parameter int NBINS_W    = 8,
  parameter int DWELL_W    = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      clk,
  input  logic                      syn_reset,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [CODE_WIDTH-1:0]     bin_step_i,
  input  logic [NBINS_W-1:0]        n_bins_i,
  input  logic [DWELL_W-1:0]        dwell_i,
  doppler_sweep_ctrl_if.slave       fs,
  output logic signed [NBINS_W:0]   bin_idx_o,
  output logic                      bin_active_o,
  output logic                      bin_end_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef DOPPLER_SWEEP_OVF_EN
  ,
  output logic                      ovf_o
`endif
);

  localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

  typedef enum logic [2:0] {
    IDLE, PRELOAD, LOAD, SETTLE, DWELL, NEXT, DONE
  } state_t;

  // With no settle window a code change goes straight to counting.
  localparam state_t AFTER_CODE = (SETTLE_CYC == 0) ? DWELL : SETTLE;

  state_t                   state_q, state_d;
  logic [CODE_WIDTH-1:0]    step_q, step_d;
  logic [NBINS_W-1:0]       nbins_q, nbins_d;
  logic [DWELL_W-1:0]       dwell_q, dwell_d;
  logic [CODE_WIDTH-1:0]    acc_q, acc_d;
  logic [NBINS_W-1:0]       pre_cnt_q, pre_cnt_d;
  logic [SW-1:0]            settle_cnt_q, settle_cnt_d;
  logic [DWELL_W-1:0]       dwell_cnt_q, dwell_cnt_d;
  logic [CODE_WIDTH-1:0]    code_q, code_d;
  logic                     code_up_q, code_up_d;
  logic signed [NBINS_W:0]  bin_idx_q, bin_idx_d;
`ifdef DOPPLER_SWEEP_OVF_EN
  logic                     ovf_q, ovf_d;
  logic                     carry;
`endif

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      nbins_q      <= '0;
      dwell_q      <= '0;
      acc_q        <= '0;
      pre_cnt_q    <= '0;
      settle_cnt_q <= '0;
      dwell_cnt_q  <= '0;
      code_q       <= '0;
      code_up_q    <= 1'b0;
      bin_idx_q    <= '0;
`ifdef DOPPLER_SWEEP_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      nbins_q      <= nbins_d;
      dwell_q      <= dwell_d;
      acc_q        <= acc_d;
      pre_cnt_q    <= pre_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      code_q       <= code_d;
      code_up_q    <= code_up_d;
      bin_idx_q    <= bin_idx_d;
`ifdef DOPPLER_SWEEP_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    nbins_d      = nbins_q;
    dwell_d      = dwell_q;
    acc_d        = acc_q;
    pre_cnt_d    = pre_cnt_q;
    settle_cnt_d = settle_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    code_d       = code_q;
    code_up_d    = code_up_q;
    bin_idx_d    = bin_idx_q;
`ifdef DOPPLER_SWEEP_OVF_EN
    ovf_d        = ovf_q;
    carry        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          step_d    = bin_step_i;
          nbins_d   = n_bins_i;
          // A zero dwell is stored as 1 so the compare below needs no special case.
          dwell_d   = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
          acc_d     = '0;
          pre_cnt_d = '0;
`ifdef DOPPLER_SWEEP_OVF_EN
          ovf_d     = 1'b0;
`endif
          state_d   = (n_bins_i == '0) ? LOAD : PRELOAD;
        end
      end

      // Build |−N| * step by repeated addition, one add per cycle.
      PRELOAD: begin
`ifdef DOPPLER_SWEEP_OVF_EN
        {carry, acc_d} = {1'b0, acc_q} + {1'b0, step_q};
        if (carry) ovf_d = 1'b1;
`else
        acc_d = acc_q + step_q;
`endif
        pre_cnt_d = pre_cnt_q + NBINS_W'(1);
        if (pre_cnt_q == nbins_q - NBINS_W'(1)) state_d = LOAD;
      end

      LOAD: begin
        code_d       = acc_q;
        code_up_d    = 1'b0;
        bin_idx_d    = -$signed({1'b0, nbins_q});
        settle_cnt_d = '0;
        dwell_cnt_d  = '0;
        state_d      = AFTER_CODE;
      end

      SETTLE: begin
        settle_cnt_d = settle_cnt_q + SW'(1);
        if (settle_cnt_q == SW'(SETTLE_CYC - 1)) state_d = DWELL;
      end

      DWELL: begin
        if (fs.valid) begin
          if (dwell_cnt_q + DWELL_W'(1) == dwell_q) begin
            dwell_cnt_d = '0;
            state_d     = NEXT;
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
      end

      // Moving toward k=0 the magnitude shrinks, past it the magnitude grows.
      NEXT: begin
        if (bin_idx_q == $signed({1'b0, nbins_q})) begin
          state_d = DONE;
        end else begin
          bin_idx_d    = bin_idx_q + $signed((NBINS_W + 1)'(1));
          code_d       = bin_idx_q[NBINS_W] ? code_q - step_q : code_q + step_q;
          code_up_d    = !bin_idx_q[NBINS_W];
          settle_cnt_d = '0;
          dwell_cnt_d  = '0;
          state_d      = AFTER_CODE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort freezes the code outputs where they are.
    if (abort_i) begin
      state_d   = IDLE;
      code_d    = code_q;
      code_up_d = code_up_q;
      bin_idx_d = bin_idx_q;
    end
  end

  assign fs.code      = code_q;
  assign fs.code_up   = code_up_q;
  assign bin_idx_o    = bin_idx_q;
  assign bin_active_o = (state_q == DWELL);
  assign bin_end_o    = (state_q == NEXT);
  assign done_o       = (state_q == DONE);
  assign busy_o       = (state_q != IDLE) && (state_q != DONE);
`ifdef DOPPLER_SWEEP_OVF_EN
  assign ovf_o        = ovf_q;
`endif

endmodule

// File: tb/tb_doppler_sweep_ctrl.sv
// tb_doppler_sweep_ctrl
//   Self-checking bench for doppler_sweep_ctrl. Sweeps are described by their
//   parameters; the expected bin sequence, codes, per-bin sample counts and
//   timing gaps come from a bin-level reference model in this file.
//   Honours DOPPLER_SWEEP_OVF_EN when defined.
module tb_doppler_sweep_ctrl;
  localparam int CW     = 32;
  localparam int NW     = 8;
  localparam int DW     = 16;
  localparam int SETTLE = 2;

  logic                 clk = 1'b0;
  logic                 syn_reset;
  logic                 start_i;
  logic                 abort_i;
  logic [CW-1:0]        bin_step_i;
  logic [NW-1:0]        n_bins_i;
  logic [DW-1:0]        dwell_i;
  logic signed [NW:0]   bin_idx_o;
  logic                 bin_active_o;
  logic                 bin_end_o;
  logic                 busy_o;
  logic                 done_o;
`ifdef DOPPLER_SWEEP_OVF_EN
  logic                 ovf_o;
`endif

  int checkCount = 0;
  int errorCount = 0;

  doppler_sweep_ctrl_if #(.CODE_WIDTH(CW)) fsIf ();

  doppler_sweep_ctrl #(
    .CODE_WIDTH(CW), .NBINS_W(NW), .DWELL_W(DW), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk          (clk),
    .syn_reset    (syn_reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .bin_step_i   (bin_step_i),
    .n_bins_i     (n_bins_i),
    .dwell_i      (dwell_i),
    .fs           (fsIf.slave),
    .bin_idx_o    (bin_idx_o),
    .bin_active_o (bin_active_o),
    .bin_end_o    (bin_end_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef DOPPLER_SWEEP_OVF_EN
    ,
    .ovf_o        (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Code magnitude of bin k: |k| * step, wrapped to CW bits.
  function automatic logic [CW-1:0] modelCode(input int k, input logic [CW-1:0] step);
    int a;
    a = (k < 0) ? -k : k;
    return CW'(a) * step;
  endfunction

  task automatic resetDut();
    @(negedge clk);
    syn_reset = 1'b1;
    repeat (3) @(negedge clk);
    syn_reset = 1'b0;
  endtask

  // Runs one full sweep. validMode: 0 always valid, 1 one-in-four, 2 coin flip.
  task automatic applyStimulus(input int n, input logic [CW-1:0] step, input int dwell,
                               input int validMode, input bit midStart);
    int  dwellEff, bin, cnt, cyc, lastEnd;
    bit  doneSeen, prevActive, v;
    logic [63:0] total;
    dwellEff   = (dwell == 0) ? 1 : dwell;
    bin        = 0;
    cnt        = 0;
    cyc        = 0;
    lastEnd    = 0;
    doneSeen   = 1'b0;
    prevActive = 1'b0;
    total      = 64'(n) * 64'(step);

    @(negedge clk);
    bin_step_i = step;
    n_bins_i   = NW'(n);
    dwell_i    = DW'(dwell);
    start_i    = 1'b1;
    fsIf.valid = 1'b0;
    @(posedge clk);

    while (!doneSeen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_i    = 1'b0;
        bin_step_i = midStart ? CW'(5) : CW'($urandom);
        n_bins_i   = NW'($urandom);
        dwell_i    = DW'($urandom);
`ifdef DOPPLER_SWEEP_OVF_EN
        checkOutput("ovfCleared", ovf_o, 0);
`endif
      end

      if (done_o) begin
        doneSeen = 1'b1;
        start_i  = 1'b0;
        checkOutput("binsSeen", bin, 2 * n + 1);
        checkOutput("busyAtDone", busy_o, 0);
      end else begin
        checkOutput("busyInSweep", busy_o, 1);
        if (bin_active_o) begin
          if (!prevActive) begin
            if (bin == 0) checkOutput("firstActiveCyc", cyc, n + 2 + SETTLE);
            else          checkOutput("settleGap", cyc - lastEnd, SETTLE + 1);
`ifdef DOPPLER_SWEEP_OVF_EN
            if (bin == 0) checkOutput("ovfByLoad", ovf_o, (total >= 64'h1_0000_0000) ? 1 : 0);
`endif
          end
          checkOutput("dwellCode", fsIf.code, modelCode(bin - n, step));
          checkOutput("dwellUp", fsIf.code_up, ((bin - n) > 0) ? 1 : 0);
          checkOutput("dwellIdx", int'(bin_idx_o), bin - n);
        end
        if (bin_end_o) begin
          checkOutput("sampleCount", cnt, dwellEff);
          checkOutput("endIdx", int'(bin_idx_o), bin - n);
          checkOutput("endCode", fsIf.code, modelCode(bin - n, step));
          if (validMode == 0 && bin > 0)
            checkOutput("endSpacing", cyc - lastEnd, 1 + SETTLE + dwellEff);
          lastEnd = cyc;
          bin++;
          cnt = 0;
        end
        prevActive = bin_active_o;

        case (validMode)
          0:       v = 1'b1;
          1:       v = ($urandom_range(0, 3) == 0);
          default: v = ($urandom_range(0, 1) == 1);
        endcase
        fsIf.valid = v;
        if (bin_active_o && v) cnt++;
        start_i = midStart && (cyc == 6);
      end
    end

    if (!doneSeen) begin
      checkOutput("sweepTimeout", 0, 1);
      resetDut();
    end else begin
      @(negedge clk);
      checkOutput("idleAfterDone", {busy_o, done_o, bin_active_o}, 0);
    end
  endtask

  // Interrupts a sweep while bin -1 is counting, by abort or by reset.
  task automatic applyAbort(input bit useReset);
    int  guard;
    int  pulses;
    guard = 0;
    @(negedge clk);
    bin_step_i = 32'h1000;
    n_bins_i   = NW'(2);
    dwell_i    = DW'(3);
    fsIf.valid = 1'b1;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (!(bin_active_o && int'(bin_idx_o) == -1) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reachBinM1", (guard < 200) ? 1 : 0, 1);
    if (useReset) syn_reset = 1'b1;
    else          abort_i   = 1'b1;
    @(negedge clk);
    syn_reset = 1'b0;
    abort_i   = 1'b0;
    checkOutput(useReset ? "rstBusy" : "abtBusy", busy_o, 0);
    checkOutput(useReset ? "rstActive" : "abtActive", bin_active_o, 0);
    checkOutput(useReset ? "rstPulses" : "abtPulses", {done_o, bin_end_o}, 0);
    checkOutput(useReset ? "rstCode" : "abtCode", fsIf.code, useReset ? 0 : 32'h1000);
    checkOutput(useReset ? "rstCodeUp" : "abtCodeUp", fsIf.code_up, 0);
    if (useReset) checkOutput("rstIdx", int'(bin_idx_o), 0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o || bin_end_o || busy_o) pulses++;
    end
    checkOutput(useReset ? "rstQuiet" : "abtQuiet", pulses, 0);
  endtask

  initial begin
    syn_reset  = 1'b1;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    bin_step_i = '0;
    n_bins_i   = '0;
    dwell_i    = '0;
    fsIf.valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetCode", fsIf.code, 0);
    checkOutput("resetOuts", {fsIf.code_up, bin_active_o, bin_end_o, busy_o, done_o}, 0);
    checkOutput("resetIdx", int'(bin_idx_o), 0);
    syn_reset = 1'b0;

    applyStimulus(2, 32'h1000, 3, 0, 1'b0);
    applyStimulus(0, CW'($urandom), 0, 1, 1'b0);
    applyAbort(1'b0);
    applyAbort(1'b1);
    applyStimulus(2, 32'h1000, 3, 0, 1'b1);
    applyStimulus(2, 32'h9000_0000, 1, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus($urandom_range(0, 4), CW'($urandom), $urandom_range(0, 4),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/doppler_sweep_ctrl.md
Name: doppler_sweep_ctrl

Overview:
- Slave-side driver of freq_shift_interface for the acquisition path.
- Steps the frequency shifter through a symmetric grid of Doppler bins, -N..+N, by driving code and code_up.
- Holds each bin stable for a programmed number of valid samples, then advances to the next bin.
- Marks bin boundaries so downstream correlator/accumulator logic can dump per-bin results.

Parameters:
CODE_WIDTH, 32, width of the shifter phase-increment code
NBINS_W, 8, width of the bins-per-side count
DWELL_W, 16, width of the per-bin sample count
SETTLE_CYC, 2, cycles after each code change during which valid is ignored (DDS/shifter pipeline flush)

Ports:
clk  in  1  system clock
syn_reset  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a sweep when idle
abort  in  1  terminates the sweep; returns to idle, no done
bin_step  in  CODE_WIDTH  code increment between adjacent bins
n_bins  in  NBINS_W  bins per side; total bins = 2*n_bins+1
dwell  in  DWELL_W  valid samples per bin; 0 is treated as 1
fs.code  out  CODE_WIDTH  freq_shift_interface code (|k|*bin_step)
fs.code_up  out  1  freq_shift_interface sign; 1 when k>0
fs.valid  in  1  freq_shift_interface sample-valid from shifter
bin_idx  out  NBINS_W+1  signed current bin index k
bin_active  out  1  high while the bin is in DWELL (samples counted)
bin_end  out  1  one-cycle pulse after the last sample of a bin
busy  out  1  high from the cycle after start until done or abort
done  out  1  one-cycle pulse when the whole sweep completes

Behaviour:
- Interface: one clock, clk. Reset syn_reset is synchronous and active-high.
- Reset values: code=0, code_up=0, bin_idx=0, bin_active=0, bin_end=0, busy=0, done=0, state IDLE.
- syn_reset asserted mid-sweep: all outputs return to their reset values on the next edge.
- start in IDLE latches bin_step, n_bins and dwell. Later changes to these inputs are ignored until the next start. start while busy is ignored.
- States:
  - IDLE.
  - PRELOAD: acc += step, repeated n_bins cycles; skipped if n_bins=0.
  - LOAD: 1 cycle; code<=acc, code_up<=0, bin_idx<=-n_bins.
  - SETTLE: SETTLE_CYC cycles; valid ignored.
  - DWELL: counts valid.
  - NEXT: 1 cycle.
  - DONE: 1 cycle; done=1, then IDLE.
- DWELL: the counter increments on each valid. When count reaches dwell (with dwell=0 treated as 1), exit to NEXT and assert bin_end for exactly that NEXT cycle. bin_idx still shows the finished bin during bin_end.
- NEXT:
  - If k==n_bins, go to DONE.
  - Otherwise k<=k+1. If old k<0, code<=code-step; else code<=code+step.
  - code_up<=(new k>0). At k=0: code=0, code_up=0.
  - Then go to SETTLE.
- code/code_up change only on entering LOAD or in NEXT. They are stable throughout SETTLE and DWELL.
- Arithmetic is modulo 2^CODE_WIDTH. Overflow is not corrected.
- abort has priority over all transitions except syn_reset. Next state is IDLE; busy=0, bin_active=0; code/code_up hold their last value; no done, no bin_end.
- busy drops in the same cycle done is asserted.

Optional Feature:
Macro DOPPLER_SWEEP_OVF_EN.
- Defined: adds output port ovf (1 bit, sticky).
  - Set if any PRELOAD addition carries out of CODE_WIDTH bits.
  - Cleared on start or syn_reset.
  - ovf is asserted by the LOAD cycle. The sweep still runs with wrapped codes.
- Undefined: no ovf port, no carry logic. Behaviour is otherwise identical.

Test Plan:
- Basic sweep. n_bins=2, bin_step=0x1000, dwell=3, valid every cycle, start pulse.
  - Codes/code_up: 0x2000/0, 0x1000/0, 0/0, 0x1000/1, 0x2000/1; bin_idx -2..2.
  - Exactly 3 valids counted per bin, 5 bin_end pulses, then done once; busy low afterwards.
- Settle masking. Same setup, valid every cycle.
  - valids in the SETTLE_CYC=2 cycles after each code change are not counted.
  - bin_end spacing from the second bin on = 1 (NEXT) + 2 (SETTLE) + 3 (DWELL) = 6 cycles.
- Degenerate inputs. n_bins=0, dwell=0, valid sparse (1 in 4).
  - No PRELOAD; single bin k=0, code=0, code_up=0.
  - One valid ends the bin; then done.
- Abort/reset mid-sweep.
  - abort during DWELL of bin -1: next cycle IDLE, busy=0, no done/bin_end, code holds 0x1000.
  - Repeat with syn_reset: code=0, all outputs at reset values.
- Input latching/start-while-busy.
  - Change bin_step to 0x5 and pulse start mid-sweep: codes unchanged, sweep continues, single done.
- Overflow (macro defined). n_bins=2, bin_step=0x9000_0000.
  - ovf=1 by LOAD; first code=0x2000_0000 (wrapped); ovf cleared by next start.
